// File: rtl/uart_boot_loader.sv
// UART (8N1) boot loader: receives a framed program image and streams it, padded to whole
// 32-bit words, into the text-memory byte port while holding the core in reset.
module uart_boot_loader #(
   parameter int unsigned CLK_DIV   = 434,
   parameter int unsigned MAX_BYTES = 4096,
   parameter logic [7:0]  MAGIC     = 8'hA5,
   parameter int unsigned TIMEOUT   = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] byte_out,
   output logic       byte_we,
   output logic       mem_rst,
   output logic       core_hold,
   output logic       done,
   output logic       err
);
   localparam logic [2:0] RX_IDLE  = 3'd0;
   localparam logic [2:0] RX_START = 3'd1;
   localparam logic [2:0] RX_DATA  = 3'd2;
   localparam logic [2:0] RX_STOP  = 3'd3;
   localparam logic [2:0] RX_WAIT  = 3'd4;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LEN_LO = 3'd1;
   localparam logic [2:0] S_LEN_HI = 3'd2;
   localparam logic [2:0] S_LOAD   = 3'd3;
   localparam logic [2:0] S_PAD    = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   localparam logic [15:0] HALF    = 16'(CLK_DIV / 2 - 1);
   localparam logic [15:0] FULL    = 16'(CLK_DIV - 1);
   localparam logic [31:0] TO_CYC  = 32'(TIMEOUT * CLK_DIV);
   localparam logic [15:0] MAX_LEN = 16'(MAX_BYTES);

   logic        rx_meta, rx_sync;
   logic [2:0]  rx_state;
   logic [15:0] div_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  rx_byte;
   logic        rx_valid, frame_err;
   logic [31:0] timer;
   logic        timeout;
   logic [2:0]  state;
   logic [15:0] len, count;
   logic [15:0] len_next, count_next;
   logic        active;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   // The synchroniser presets high so reset release never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state  <= RX_IDLE;
         div_cnt   <= '0;
         bit_idx   <= '0;
         rx_byte   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (!rx_sync) begin
                  rx_state <= RX_START;
                  div_cnt  <= '0;
               end
            end
            RX_START: begin
               if (div_cnt == HALF) begin
                  div_cnt  <= '0;
                  bit_idx  <= '0;
                  rx_state <= rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  div_cnt <= div_cnt + 16'd1;
               end
            end
            RX_DATA: begin
               if (div_cnt == FULL) begin
                  div_cnt <= '0;
                  rx_byte <= {rx_sync, rx_byte[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) rx_state <= RX_STOP;
               end else begin
                  div_cnt <= div_cnt + 16'd1;
               end
            end
            RX_STOP: begin
               if (div_cnt == FULL) begin
                  div_cnt <= '0;
                  if (rx_sync) begin
                     rx_valid <= 1'b1;
                     rx_state <= RX_IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     rx_state  <= RX_WAIT;
                  end
               end else begin
                  div_cnt <= div_cnt + 16'd1;
               end
            end
            RX_WAIT:  if (rx_sync) rx_state <= RX_IDLE;
            default:  rx_state <= RX_IDLE;
         endcase
      end
   end

   // Inter-byte timer counts idle-line time only, so a byte in flight never trips it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                timer <= '0;
      else if (rx_valid || rx_state != RX_IDLE)  timer <= '0;
      else if (timer != TO_CYC)                  timer <= timer + 32'd1;
   end

   assign timeout    = (TIMEOUT != 0) && (timer == TO_CYC);
   assign len_next   = {rx_byte, len[7:0]};
   assign count_next = count + 16'd1;
   assign active     = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                       (state == S_LOAD)   || (state == S_PAD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         len       <= '0;
         count     <= '0;
         byte_out  <= '0;
         byte_we   <= 1'b0;
         mem_rst   <= 1'b0;
         core_hold <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         byte_we <= 1'b0;
         mem_rst <= 1'b0;
         if (active && (frame_err || timeout)) begin
            err   <= 1'b1;
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (rx_valid && rx_byte == MAGIC) begin
                     mem_rst   <= 1'b1;
                     core_hold <= 1'b1;
                     done      <= 1'b0;
                     err       <= 1'b0;
                     count     <= '0;
                     state     <= S_LEN_LO;
                  end
               end
               S_LEN_LO: begin
                  if (rx_valid) begin
                     len[7:0] <= rx_byte;
                     state    <= S_LEN_HI;
                  end
               end
               S_LEN_HI: begin
                  if (rx_valid) begin
                     len[15:8] <= rx_byte;
                     if (len_next == 16'd0 || len_next > MAX_LEN) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                     end else begin
                        state <= S_LOAD;
                     end
                  end
               end
               S_LOAD: begin
                  if (rx_valid) begin
                     byte_out <= rx_byte;
                     byte_we  <= 1'b1;
                     count    <= count_next;
                     if (count_next == len) state <= (len[1:0] != 2'd0) ? S_PAD : S_DONE;
                  end
               end
               S_PAD: begin
                  byte_out <= 8'h00;
                  byte_we  <= 1'b1;
                  count    <= count_next;
                  if (count_next[1:0] == 2'd0) state <= S_DONE;
               end
               S_DONE: begin
                  done      <= 1'b1;
                  core_hold <= 1'b0;
                  state     <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule
